// File: rtl/elc_multi_if.sv
// Keypad/card front end to lock controller bundle. The master drives the keypad
// and card inputs. The slave (the lock controller) drives the door and status outputs.
interface elc_multi_if #(
    parameter int DIGIT_W = 3,
    parameter int TRIES_W = 2
);
    logic [DIGIT_W-1:0] in_i;
    logic               enter_i;
    logic               clear_i;
    logic               card_is_in_i;
    logic               unlock_o;
    logic               error_o;
    logic               card_is_needed_o;
    logic               busy_o;
    logic [TRIES_W-1:0] tries_o;

    modport master (
        output in_i, enter_i, clear_i, card_is_in_i,
        input  unlock_o, error_o, card_is_needed_o, busy_o, tries_o
    );

    modport slave (
        input  in_i, enter_i, clear_i, card_is_in_i,
        output unlock_o, error_o, card_is_needed_o, busy_o, tries_o
    );
endinterface

// File: rtl/elc_multi.sv
// Electronic lock controller: multi-digit keypad code, penalty waits that grow
// with failures, card fallback after MAX_TRIES failures and a timed unlock pulse.
module elc_multi #(
    parameter int DIGIT_W    = 3,
    parameter int NUM_DIGITS = 2,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] CODE = 6'o52,
    parameter int MAX_TRIES  = 3,
    parameter int SHORT_WAIT = 8,
    parameter int LONG_WAIT  = 32,
    parameter int UNLOCK_CYC = 4
) (
    input  logic       clk,
    input  logic       reset,
    elc_multi_if.slave bus
);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int CNT_MAX0 = (LONG_WAIT > UNLOCK_CYC) ? LONG_WAIT : UNLOCK_CYC;
    localparam int CNT_MAX  = (SHORT_WAIT > CNT_MAX0) ? SHORT_WAIT : CNT_MAX0;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   SHORT_LOAD  = CNT_W'(SHORT_WAIT - 1);
    localparam logic [CNT_W-1:0]   LONG_LOAD   = CNT_W'(LONG_WAIT - 1);
    localparam logic [CNT_W-1:0]   UNLOCK_LOAD = CNT_W'(UNLOCK_CYC - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_DIGITS - 1);
    localparam logic [TRIES_W-1:0] TRIES_MAX   = TRIES_W'(MAX_TRIES);
    localparam logic [TRIES_W-1:0] TRIES_ONE   = TRIES_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENALTY = 2'd1,
        S_CARD    = 2'd2,
        S_UNLOCK  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               mism_q, mism_d;
    logic [TRIES_W-1:0] fails_q, fails_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               digit_bad;
    logic               any_bad;
    logic               last_digit;
    logic [TRIES_W-1:0] fails_inc;

    // Code split into digits, first-entered digit taken from the MS slice.
    // Unused table slots (non power-of-two digit counts) read as zero.
    logic [DIGIT_W-1:0] code_digits [2**IDX_W];

    for (genvar gi = 0; gi < 2**IDX_W; gi++) begin : g_code
        if (gi < NUM_DIGITS) begin : g_used
            assign code_digits[gi] = CODE[(NUM_DIGITS-1-gi)*DIGIT_W +: DIGIT_W];
        end else begin : g_pad
            assign code_digits[gi] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            mism_q  <= 1'b0;
            fails_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mism_q  <= mism_d;
            fails_q <= fails_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mism_d     = mism_q;
        fails_d    = fails_q;
        cnt_d      = cnt_q;
        digit_bad  = (bus.in_i != code_digits[idx_q]);
        any_bad    = mism_q | digit_bad;
        last_digit = (idx_q == LAST_IDX);
        fails_inc  = (fails_q >= TRIES_MAX) ? fails_q : fails_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (bus.clear_i) begin
                    idx_d  = '0;
                    mism_d = 1'b0;
                end else if (bus.enter_i) begin
                    if (!last_digit) begin
                        // A wrong digit is only remembered, never acted on early.
                        idx_d  = idx_q + 1'b1;
                        mism_d = any_bad;
                    end else begin
                        idx_d  = '0;
                        mism_d = 1'b0;
                        if (!any_bad) begin
                            state_d = S_UNLOCK;
                            cnt_d   = UNLOCK_LOAD;
                            fails_d = '0;
                        end else begin
                            fails_d = fails_inc;
                            if (fails_inc >= TRIES_MAX) begin
                                state_d = S_CARD;
                            end else begin
                                state_d = S_PENALTY;
                                cnt_d   = (fails_inc == TRIES_ONE) ? SHORT_LOAD : LONG_LOAD;
                            end
                        end
                    end
                end
            end
            S_PENALTY: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CARD: begin
                if (bus.card_is_in_i) begin
                    state_d = S_UNLOCK;
                    cnt_d   = UNLOCK_LOAD;
                    fails_d = '0;
                end
            end
            S_UNLOCK: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.unlock_o         = (state_q == S_UNLOCK);
        bus.error_o          = (state_q == S_PENALTY);
        bus.card_is_needed_o = (state_q == S_CARD);
        bus.busy_o           = (state_q == S_IDLE) && (idx_q != '0);
        bus.tries_o          = fails_q;
    end
endmodule

// File: tb/tb_elc_multi.sv
// Bench for elc_multi: default 2-digit lock checked against a queue-based model,
// plus a 4-digit (16'h9A3C) instance checked with directed expectations.
module tb_elc_multi;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    elc_multi_if #(.DIGIT_W(3), .TRIES_W(2)) bus_a ();
    elc_multi_if #(.DIGIT_W(4), .TRIES_W(2)) bus_b ();

    elc_multi u_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_a)
    );

    elc_multi #(
        .DIGIT_W    (4),
        .NUM_DIGITS (4),
        .CODE       (16'h9A3C)
    ) u_b (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_b)
    );

    // Reference model of the default lock: entered digits kept in a queue,
    // timers kept as "cycles of the current phase still to show".
    localparam int M_IDLE = 0, M_PEN = 1, M_CARD = 2, M_UNL = 3;
    int code_a [2] = '{5, 2};
    int m_mode;
    int m_q [$];
    int m_fails;
    int m_remain;

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_q.delete();
        m_fails  = 0;
        m_remain = 0;
    endtask

    task automatic model_step();
        bit ok;
        case (m_mode)
            M_IDLE: begin
                if (bus_a.clear_i) begin
                    m_q.delete();
                end else if (bus_a.enter_i) begin
                    m_q.push_back(int'(bus_a.in_i));
                    if (m_q.size() == 2) begin
                        ok = 1'b1;
                        foreach (m_q[k]) if (m_q[k] != code_a[k]) ok = 1'b0;
                        m_q.delete();
                        if (ok) begin
                            m_mode = M_UNL; m_remain = 4; m_fails = 0;
                        end else begin
                            if (m_fails < 3) m_fails++;
                            if (m_fails == 3) m_mode = M_CARD;
                            else begin
                                m_mode = M_PEN;
                                m_remain = (m_fails == 1) ? 8 : 32;
                            end
                        end
                    end
                end
            end
            M_PEN, M_UNL: begin
                m_remain--;
                if (m_remain == 0) m_mode = M_IDLE;
            end
            M_CARD: begin
                if (bus_a.card_is_in_i) begin
                    m_mode = M_UNL; m_remain = 4; m_fails = 0;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    function automatic logic [5:0] exp_a();
        return {m_mode == M_UNL, m_mode == M_PEN, m_mode == M_CARD,
                (m_mode == M_IDLE) && (m_q.size() != 0), 2'(m_fails)};
    endfunction

    function automatic logic [5:0] obs_a();
        return {bus_a.unlock_o, bus_a.error_o, bus_a.card_is_needed_o, bus_a.busy_o, bus_a.tries_o};
    endfunction

    function automatic logic [5:0] obs_b();
        return {bus_b.unlock_o, bus_b.error_o, bus_b.card_is_needed_o, bus_b.busy_o, bus_b.tries_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic press_a(input int d);
        bus_a.in_i = 3'(d);
        bus_a.enter_i = 1'b1;
        tick();
        bus_a.enter_i = 1'b0;
    endtask

    task automatic press_b(input int d);
        bus_b.in_i = 4'(d);
        bus_b.enter_i = 1'b1;
        tick();
        bus_b.enter_i = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (obs_a() !== 6'b0) begin n_fail++; $display("FAIL reset_a: got %b want %b", obs_a(), 6'b0); end
        n_tests++;
        if (obs_b() !== 6'b0) begin n_fail++; $display("FAIL reset_b: got %b want %b", obs_b(), 6'b0); end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (obs_a() !== exp_a()) begin n_fail++; $display("FAIL reset_release: got %b want %b", obs_a(), exp_a()); end
    endtask

    task automatic test_unlock();
        logic [7:0] mask;
        press_a(5);
        n_tests++;
        if (bus_a.busy_o !== 1'b1 || obs_a() !== exp_a()) begin
            n_fail++; $display("FAIL unlock_busy: got %b want %b", obs_a(), exp_a());
        end
        press_a(2);
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (obs_a() !== exp_a()) begin n_fail++; $display("FAIL unlock_cyc%0d: got %b want %b", i, obs_a(), exp_a()); end
            mask[i] = bus_a.unlock_o;
            n_tests++;
            if (bus_a.error_o !== 1'b0 || bus_a.tries_o !== 2'd0) begin
                n_fail++; $display("FAIL unlock_err_tries%0d: got err=%b tries=%0d want err=0 tries=0", i, bus_a.error_o, bus_a.tries_o);
            end
            tick();
        end
        n_tests++;
        if (mask !== 8'b0000_1111) begin n_fail++; $display("FAIL unlock_window: got %b want %b", mask, 8'b0000_1111); end
    endtask

    task automatic test_penalty();
        int errs;
        press_a(5);
        press_a(3);
        errs = 0;
        for (int i = 0; i < 12; i++) begin
            n_tests++;
            if (obs_a() !== exp_a() || bus_a.busy_o !== 1'b0) begin
                n_fail++; $display("FAIL penalty_cyc%0d: got %b want %b", i, obs_a(), exp_a());
            end
            if (bus_a.error_o) errs++;
            bus_a.in_i = 3'd5;
            bus_a.enter_i = (i < 5) && (i % 2 == 0);
            tick();
        end
        bus_a.enter_i = 1'b0;
        n_tests++;
        if (errs !== 8) begin n_fail++; $display("FAIL penalty_len: got %0d want %0d", errs, 8); end
        press_a(5);
        press_a(2);
        n_tests++;
        if (bus_a.unlock_o !== 1'b1 || bus_a.tries_o !== 2'd0 || obs_a() !== exp_a()) begin
            n_fail++; $display("FAIL penalty_then_unlock: got %b want %b", obs_a(), exp_a());
        end
        repeat (6) tick();
    endtask

    task automatic test_card();
        int errs;
        press_a(1); press_a(1);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_a.error_o) errs++;
            tick();
        end
        n_tests++;
        if (errs !== 8) begin n_fail++; $display("FAIL card_wait1: got %0d want %0d", errs, 8); end
        press_a(1); press_a(1);
        errs = 0;
        for (int i = 0; i < 36; i++) begin
            n_tests++;
            if (obs_a() !== exp_a()) begin n_fail++; $display("FAIL card_wait2_cyc%0d: got %b want %b", i, obs_a(), exp_a()); end
            if (bus_a.error_o) errs++;
            tick();
        end
        n_tests++;
        if (errs !== 32) begin n_fail++; $display("FAIL card_wait2: got %0d want %0d", errs, 32); end
        press_a(1); press_a(1);
        n_tests++;
        if (obs_a() !== 6'b001011) begin n_fail++; $display("FAIL card_needed: got %b want %b", obs_a(), 6'b001011); end
        press_a(5); press_a(2);
        n_tests++;
        if (obs_a() !== 6'b001011 || obs_a() !== exp_a()) begin
            n_fail++; $display("FAIL card_code_ignored: got %b want %b", obs_a(), 6'b001011);
        end
        bus_a.card_is_in_i = 1'b1;
        tick();
        bus_a.card_is_in_i = 1'b0;
        n_tests++;
        if (obs_a() !== 6'b100000) begin n_fail++; $display("FAIL card_unlock: got %b want %b", obs_a(), 6'b100000); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (obs_a() !== exp_a()) begin n_fail++; $display("FAIL card_tail%0d: got %b want %b", i, obs_a(), exp_a()); end
        end
    endtask

    task automatic test_clear();
        press_a(5);
        bus_a.clear_i = 1'b1;
        tick();
        bus_a.clear_i = 1'b0;
        n_tests++;
        if (bus_a.busy_o !== 1'b0) begin n_fail++; $display("FAIL clear_busy: got %b want %b", bus_a.busy_o, 1'b0); end
        press_a(2); press_a(2);
        n_tests++;
        if (obs_a() !== 6'b010001 || obs_a() !== exp_a()) begin
            n_fail++; $display("FAIL clear_fail_counted: got %b want %b", obs_a(), 6'b010001);
        end
        repeat (10) tick();
        bus_a.in_i = 3'd5;
        bus_a.enter_i = 1'b1;
        bus_a.clear_i = 1'b1;
        tick();
        bus_a.enter_i = 1'b0;
        bus_a.clear_i = 1'b0;
        n_tests++;
        if (bus_a.busy_o !== 1'b0 || obs_a() !== exp_a()) begin
            n_fail++; $display("FAIL clear_wins: got %b want %b", obs_a(), exp_a());
        end
        press_a(5); press_a(2);
        n_tests++;
        if (bus_a.unlock_o !== 1'b1) begin n_fail++; $display("FAIL clear_recover: got %b want %b", bus_a.unlock_o, 1'b1); end
        repeat (6) tick();
    endtask

    task automatic test_async_reset();
        press_a(5); press_a(3);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (obs_a() !== 6'b0) begin n_fail++; $display("FAIL areset_penalty: got %b want %b", obs_a(), 6'b0); end
        tick();
        rst_n = 1'b1;
        press_a(5); press_a(2);
        n_tests++;
        if (bus_a.unlock_o !== 1'b1 || obs_a() !== exp_a()) begin
            n_fail++; $display("FAIL areset_unlock1: got %b want %b", obs_a(), exp_a());
        end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (obs_a() !== 6'b0) begin n_fail++; $display("FAIL areset_unlock: got %b want %b", obs_a(), 6'b0); end
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (obs_a() !== exp_a()) begin n_fail++; $display("FAIL areset_idle: got %b want %b", obs_a(), exp_a()); end
        press_a(5); press_a(2);
        n_tests++;
        if (bus_a.unlock_o !== 1'b1) begin n_fail++; $display("FAIL areset_unlock2: got %b want %b", bus_a.unlock_o, 1'b1); end
        repeat (6) tick();
    endtask

    task automatic test_card_ignored();
        int unl;
        unl = 0;
        bus_a.card_is_in_i = 1'b1;
        repeat (3) begin
            tick();
            if (bus_a.unlock_o) unl++;
        end
        bus_a.card_is_in_i = 1'b0;
        press_a(1); press_a(1);
        bus_a.card_is_in_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (obs_a() !== exp_a()) begin n_fail++; $display("FAIL cardign_cyc%0d: got %b want %b", i, obs_a(), exp_a()); end
            if (bus_a.unlock_o) unl++;
            tick();
        end
        bus_a.card_is_in_i = 1'b0;
        n_tests++;
        if (unl !== 0) begin n_fail++; $display("FAIL card_ignored: got %0d unlock cycles want 0", unl); end
    endtask

    task automatic test_wide();
        press_b(9); press_b(10); press_b(3);
        n_tests++;
        if (obs_b() !== 6'b000100) begin n_fail++; $display("FAIL wide_busy: got %b want %b", obs_b(), 6'b000100); end
        press_b(12);
        n_tests++;
        if (obs_b() !== 6'b100000) begin n_fail++; $display("FAIL wide_unlock: got %b want %b", obs_b(), 6'b100000); end
        repeat (6) tick();
        n_tests++;
        if (obs_b() !== 6'b0) begin n_fail++; $display("FAIL wide_relock: got %b want %b", obs_b(), 6'b0); end
        press_b(9); press_b(10); press_b(3); press_b(11);
        n_tests++;
        if (obs_b() !== 6'b010001) begin n_fail++; $display("FAIL wide_wrong_last: got %b want %b", obs_b(), 6'b010001); end
        repeat (10) tick();
        n_tests++;
        if (obs_b() !== 6'b000001) begin n_fail++; $display("FAIL wide_wait1: got %b want %b", obs_b(), 6'b000001); end
        press_b(12); press_b(3); press_b(10); press_b(9);
        n_tests++;
        if (obs_b() !== 6'b010010) begin n_fail++; $display("FAIL wide_reversed: got %b want %b", obs_b(), 6'b010010); end
        repeat (34) tick();
        n_tests++;
        if (obs_b() !== 6'b000010) begin n_fail++; $display("FAIL wide_wait2: got %b want %b", obs_b(), 6'b000010); end
        press_b(10); press_b(9); press_b(3); press_b(12);
        n_tests++;
        if (obs_b() !== 6'b001011) begin n_fail++; $display("FAIL wide_swapped: got %b want %b", obs_b(), 6'b001011); end
        bus_b.card_is_in_i = 1'b1;
        tick();
        bus_b.card_is_in_i = 1'b0;
        n_tests++;
        if (obs_b() !== 6'b100000) begin n_fail++; $display("FAIL wide_card: got %b want %b", obs_b(), 6'b100000); end
        repeat (6) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) != 0 && m_q.size() < 2)
                bus_a.in_i = 3'(code_a[m_q.size()]);
            else
                bus_a.in_i = 3'($urandom_range(0, 7));
            bus_a.enter_i      = ($urandom_range(0, 1) == 1);
            bus_a.clear_i      = ($urandom_range(0, 15) == 0);
            bus_a.card_is_in_i = ($urandom_range(0, 7) == 0);
            tick();
            n_tests++;
            if (obs_a() !== exp_a()) begin n_fail++; $display("FAIL random_cyc%0d: got %b want %b", i, obs_a(), exp_a()); end
        end
        bus_a.enter_i = 1'b0;
        bus_a.clear_i = 1'b0;
        bus_a.card_is_in_i = 1'b0;
    endtask

    initial begin
        bus_a.in_i = '0; bus_a.enter_i = 1'b0; bus_a.clear_i = 1'b0; bus_a.card_is_in_i = 1'b0;
        bus_b.in_i = '0; bus_b.enter_i = 1'b0; bus_b.clear_i = 1'b0; bus_b.card_is_in_i = 1'b0;
        test_reset();
        test_unlock();
        test_penalty();
        test_card();
        test_clear();
        test_async_reset();
        test_card_ignored();
        test_wide();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
